// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM main control FSM: state codes,
// datapath mux selects and instruction Op classes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    LINK     = 4'd10,
    MUL      = 4'd11,
    MULWB    = 4'd12,
    UNDEF    = 4'd13
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_PRODUCT   = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] SRCB_ZERO   = 2'b11;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM datapath with memory wait states,
// a counted multi-cycle multiply, branch-with-link and an undefined-op trap.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES  = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       IsLink,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       LinkW,
  output logic       MulStart,
  output logic       Trap,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State
);

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     state, next;
  logic [3:0] cnt, cntNext;
  logic       ready;
  logic       mulDone;
  logic       unused_funct;

  assign ready        = MEM_WAIT_EN ? MemReady : 1'b1;
  assign mulDone      = (cnt == MUL_LAST);
  assign unused_funct = ^Funct[4:1];
  assign State        = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= cntNext;
    end
  end

  // The counter only runs while staying in MUL, so it reads 0 everywhere else.
  always_comb begin
    next    = FETCH;
    cntNext = '0;
    case (state)
      FETCH:    next = ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_MEM:  next = MEMADR;
          OP_DP: begin
            if (IsMul)         next = MUL;
            else if (Funct[5]) next = EXECI;
            else               next = EXECR;
          end
          OP_BR:   next = IsLink ? LINK : BRANCH;
          default: next = UNDEF;
        endcase
      end
      MEMADR:   next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next = ready ? MEMWB : MEMREAD;
      MEMWRITE: next = ready ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      LINK:     next = BRANCH;
      MUL: begin
        if (mulDone) begin
          next = MULWB;
        end else begin
          next    = MUL;
          cntNext = cnt + 4'd1;
        end
      end
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    LinkW     = 1'b0;
    MulStart  = 1'b0;
    Trap      = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_WDATA;
    case (state)
      FETCH: begin
        IRWrite   = ready;
        NextPC    = ready;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR:   ALUSrcB = SRCB_EXTIMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = RES_DATA;
      end
      EXECR:    ALUOp = 1'b1;
      EXECI: begin
        ALUOp   = 1'b1;
        ALUSrcB = SRCB_EXTIMM;
      end
      ALUWB:    RegW = 1'b1;
      // PC already holds BL address + 4, so LR gets PC + 0.
      LINK: begin
        RegW      = 1'b1;
        LinkW     = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_ZERO;
        ResultSrc = RES_ALURESULT;
      end
      BRANCH: begin
        Branch    = 1'b1;
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
      end
      MUL:      MulStart = (cnt == 4'd0);
      MULWB: begin
        RegW      = 1'b1;
        ResultSrc = RES_PRODUCT;
      end
      UNDEF:    Trap = 1'b1;
      default: ;
    endcase
  end

endmodule
